// File: rtl/cr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cr_pkg
// Brief    : Shared constants for the shadowed control-register bank.
// Revision : 1.0 - initial release
// ============================================================================
package cr_pkg;

    // Register indices
    localparam int CR_TIMING    = 0;
    localparam int CR_RNG_PRD   = 1;
    localparam int CR_RNG_ADDR  = 2;
    localparam int CR_RNG_IDX12 = 3;
    localparam int CR_RNG_IDX34 = 4;
    localparam int CR_RNG_BOOST = 5;

    // Field positions inside CR_TIMING
    localparam int CR_RC_T1_LSB   = 0;
    localparam int CR_RC_T1_W     = 4;
    localparam int CR_RC_T2_LSB   = 4;
    localparam int CR_RC_T2_W     = 4;
    localparam int CR_RLRD_T1_LSB = 8;
    localparam int CR_RLRD_T1_W   = 4;

    // Reset value of CR_TIMING; every other register resets to zero
    localparam logic [31:0] CR_TIMING_RESET = 32'h0000_0455;

    // Commit FSM encoding
    localparam int         CR_ST_W       = 2;
    localparam logic [1:0] CR_ST_IDLE    = 2'd0;
    localparam logic [1:0] CR_ST_PENDING = 2'd1;
    localparam logic [1:0] CR_ST_APPLY   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cr_commit_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cr_commit_fsm
// Brief    : Holds commits until the scheduler is idle, then applies them.
// Revision : 1.0 - initial release
// ============================================================================
module cr_commit_fsm
    import cr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cr_commit,
    input  logic ctrl_idle,
    output logic cr_wready,
    output logic cr_commit_pending,
    output logic cr_update,
    output logic apply
);

    logic [CR_ST_W-1:0] r_state;
    logic [CR_ST_W-1:0] w_next;
    logic               r_update;

    // Commit pulses arriving while PENDING or APPLY merge into the one in flight
    always_comb begin
        w_next = r_state;
        case (r_state)
            CR_ST_IDLE:    if (cr_commit) w_next = ctrl_idle ? CR_ST_APPLY : CR_ST_PENDING;
            CR_ST_PENDING: if (ctrl_idle) w_next = CR_ST_APPLY;
            CR_ST_APPLY:   w_next = CR_ST_IDLE;
            default:       w_next = CR_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= CR_ST_IDLE;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_update <= (r_state == CR_ST_APPLY);
        end
    end

    assign apply             = (r_state == CR_ST_APPLY);
    assign cr_wready         = (r_state == CR_ST_IDLE);
    assign cr_commit_pending = (r_state == CR_ST_PENDING);
    assign cr_update         = r_update;

endmodule
`default_nettype wire

// File: rtl/cr_bank_shadowed.sv
`default_nettype none
// ============================================================================
// Module   : cr_bank_shadowed
// Brief    : Shadowed control-register bank with atomic idle-gated commit.
// Revision : 1.0 - initial release
// ============================================================================
module cr_bank_shadowed
    import cr_pkg::*;
#(
    parameter int                          N_REGS     = 16,
    parameter int                          DATA_W     = 32,
    parameter int                          ADDR_W     = $clog2(N_REGS),
    parameter logic [N_REGS*DATA_W-1:0]    RESET_VALS = (N_REGS*DATA_W)'(CR_TIMING_RESET)
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          cr_waddr,
    input  logic [DATA_W-1:0]          cr_wdata,
    input  logic [DATA_W/8-1:0]        cr_wstrb,
    input  logic                       cr_wvalid,
    output logic                       cr_wready,
    output logic                       cr_werr,
    input  logic                       cr_commit,
    output logic                       cr_commit_pending,
    output logic                       cr_update,
    input  logic                       ctrl_idle,
    input  logic [ADDR_W-1:0]          cr_raddr,
    input  logic                       cr_rsel,
    input  logic                       cr_rvalid,
    output logic [DATA_W-1:0]          cr_rdata,
    output logic                       cr_rdata_valid,
    output logic [N_REGS*DATA_W-1:0]   cr_active
);

    localparam int c_strb_w = DATA_W / 8;

    logic [DATA_W-1:0] r_shadow [N_REGS];
    logic [DATA_W-1:0] r_active [N_REGS];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rmux;
    logic              r_rdata_valid;
    logic              r_werr;
    logic              w_wready;
    logic              w_apply;
    logic              w_wr;
    logic              w_waddr_ok;

    cr_commit_fsm u_fsm (
        .clk               (clk),
        .rst               (rst),
        .cr_commit         (cr_commit),
        .ctrl_idle         (ctrl_idle),
        .cr_wready         (w_wready),
        .cr_commit_pending (cr_commit_pending),
        .cr_update         (cr_update),
        .apply             (w_apply)
    );

    assign w_wr       = cr_wvalid && w_wready;
    assign w_waddr_ok = (32'(cr_waddr) < N_REGS);

    // wready is low in APPLY, so shadow writes never race the copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_shadow[i] <= RESET_VALS[i*DATA_W +: DATA_W];
                r_active[i] <= RESET_VALS[i*DATA_W +: DATA_W];
            end
            r_werr <= 1'b0;
        end else begin
            r_werr <= w_wr && !w_waddr_ok;
            for (int i = 0; i < N_REGS; i++) begin
                for (int b = 0; b < c_strb_w; b++) begin
                    if (w_wr && (cr_waddr == ADDR_W'(i)) && cr_wstrb[b])
                        r_shadow[i][b*8 +: 8] <= cr_wdata[b*8 +: 8];
                end
                if (w_apply)
                    r_active[i] <= r_shadow[i];
            end
        end
    end

    always_comb begin
        w_rmux = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (cr_raddr == ADDR_W'(i))
                w_rmux = cr_rsel ? r_active[i] : r_shadow[i];
        end
    end

    // Read data holds between requests; only the valid flag drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= cr_rvalid;
            if (cr_rvalid)
                r_rdata <= w_rmux;
        end
    end

    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_active
        assign cr_active[gi*DATA_W +: DATA_W] = r_active[gi];
    end

    assign cr_wready      = w_wready;
    assign cr_werr        = r_werr;
    assign cr_rdata       = r_rdata;
    assign cr_rdata_valid = r_rdata_valid;

endmodule
`default_nettype wire

// File: doc/cr_bank_shadowed.md
Name: cr_bank_shadowed

Overview:
- Parametrised control-register bank for the memory controller, generalising the fixed 16x32 timing/D-RaNGe register file.
- Writes land in a shadow copy with byte strobes; a commit copies shadow to the active copy atomically, only while the command scheduler reports idle. Timing and RNG parameters therefore never change mid-command.
- Adds a readback port, per-register reset values and a commit-pending handshake.

Parameters:
- N_REGS, 16, number of registers (2..256).
- DATA_W, 32, register width; multiple of 8.
- ADDR_W, $clog2(N_REGS), address width.
- RESET_VALS, {N_REGS*DATA_W{1'b0}} with reg0 = 32'h00000455, flattened per-register reset values (reg i at [i*DATA_W +: DATA_W]).

Ports:
- clk  in  1  controller clock.
- rst  in  1  asynchronous, active-high reset.
- cr_waddr  in  ADDR_W  shadow write address.
- cr_wdata  in  DATA_W  write data.
- cr_wstrb  in  DATA_W/8  byte enables.
- cr_wvalid  in  1  write request.
- cr_wready  out  1  write accepted when wvalid&&wready.
- cr_werr  out  1  one-cycle pulse: accepted write with cr_waddr >= N_REGS (dropped).
- cr_commit  in  1  commit request pulse.
- cr_commit_pending  out  1  commit requested, not yet applied.
- cr_update  out  1  one-cycle pulse in the cycle active regs change.
- ctrl_idle  in  1  scheduler has no command in flight.
- cr_raddr  in  ADDR_W  read address.
- cr_rsel  in  1  0 = read shadow, 1 = read active.
- cr_rvalid  in  1  read request.
- cr_rdata  out  DATA_W  read data.
- cr_rdata_valid  out  1  read data valid.
- cr_active  out  N_REGS*DATA_W  flattened active registers, feeding timing/RNG consumers.

Behaviour:
- Reset (async assert, sync-release handled upstream): shadow and active = RESET_VALS; FSM = IDLE; cr_wready = 1; cr_commit_pending, cr_update, cr_werr, cr_rdata_valid = 0; cr_rdata = 0.
- Write: on wvalid&&wready, each byte b with wstrb[b]=1 is written to shadow[waddr] at the next edge. Strobe 0 leaves the byte unchanged. An out-of-range address changes nothing and pulses cr_werr the next cycle.
- FSM IDLE:
  - cr_commit=1 and ctrl_idle=1 -> APPLY.
  - cr_commit=1 and ctrl_idle=0 -> PENDING.
- FSM PENDING: cr_commit_pending=1, cr_wready=0 (shadow frozen). Moves to APPLY on the first cycle with ctrl_idle=1. Extra cr_commit pulses are merged, not queued.
- FSM APPLY (one cycle): active <= shadow for all registers. cr_update=1 in the cycle active changes (the cycle after entering APPLY). cr_wready stays 0 through the copy edge. Returns to IDLE.
- Commit latency:
  - ctrl_idle high: commit at edge k -> active valid and cr_update=1 after edge k+2.
  - Otherwise: 2 edges after ctrl_idle first seen high in PENDING.
- Simultaneous wvalid and cr_commit in IDLE: the write is accepted and included in the commit (write first).
- Read: rvalid at edge k -> cr_rdata / cr_rdata_valid=1 after edge k (1-cycle latency, registered). Reads are never stalled. A read in the same cycle as a write to the same shadow register returns the old value. Out-of-range cr_raddr returns 0.
- cr_rdata holds its last value when rvalid=0; only rdata_valid drops.
- Reset mid-PENDING/APPLY: the commit is abandoned, all state goes to the reset values, and no cr_update pulse is produced.

Decomposition:
- Shared package cr_pkg: register index constants (CR_TIMING=0, CR_RNG_PRD=1, CR_RNG_ADDR=2, CR_RNG_IDX12=3, CR_RNG_IDX34=4, CR_RNG_BOOST=5), field offsets within CR_TIMING (rc_t1 [3:0], rc_t2 [7:4], rlrd_t1 [11:8]), default reset vector, FSM state encoding.
- One sub-module, cr_commit_fsm (IDLE/PENDING/APPLY, wready/pending/update generation). The storage arrays stay in the top.

Test Plan:
- Reset, then read active reg0 with rsel=1 -> rdata=32'h00000455 and rdata_valid next cycle. Other registers read 0. cr_active[31:0]=32'h455.
- Write reg1=32'hDEADBEEF with wstrb=4'b0101, no commit -> shadow reg1 reads 32'h00AD00EF; active reg1 still 0.
- ctrl_idle=0, commit -> commit_pending=1 and wready=0 for 10 cycles; a wvalid write to reg2 is not accepted. Raise ctrl_idle -> cr_update after 2 edges, active reg1=32'h00AD00EF, wready returns 1.
- Same-cycle write reg0=32'h00000333 (wstrb all ones) and commit with ctrl_idle=1 -> active reg0=32'h333 after 2 edges, exactly one cr_update pulse.
- Write to address N_REGS (param N_REGS=12, ADDR_W=4, addr 12) -> cr_werr pulse, no register changes. Read addr 13 -> rdata=0.
- Assert rst while PENDING -> commit_pending=0 immediately (async), active/shadow at reset values, no cr_update after release.
